// File: rtl/maze_pkg.sv
// Shared definitions for the maze path checker: solver action codes,
// coordinate and buffer sizes, cell codes, checker states, error bits.
package maze_pkg;

  // Coordinate is {x[2:0], y[2:0]}, so an 8x8 maze has 64 cells
  localparam int COORD_W = 6;
  localparam int SIZE    = 64;
  localparam int CNT_W   = 7;

  // Solver action codes seen on action_i
  localparam logic [1:0] ACT_IDLE   = 2'b00;
  localparam logic [1:0] ACT_INPUT  = 2'b01;
  localparam logic [1:0] ACT_CAL    = 2'b10;
  localparam logic [1:0] ACT_OUTPUT = 2'b11;

  // Cell codes carried in the solver's row words (two bits per cell)
  localparam logic [1:0] CELL_FREE  = 2'b00;
  localparam logic [1:0] CELL_WALL  = 2'b01;
  localparam logic [1:0] CELL_START = 2'b10;
  localparam logic [1:0] CELL_END   = 2'b11;

  // Checker state encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SNOOP    = 3'd1;
  localparam logic [2:0] ST_WAIT_CAL = 3'd2;
  localparam logic [2:0] ST_CAPTURE  = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  // Error flag bit positions in err_o
  localparam int ERR_ADJ     = 0;
  localparam int ERR_REVISIT = 1;
  localparam int ERR_ENDPT   = 2;
  localparam int ERR_TIMEOUT = 3;

  // The 9th INPUT word carries start/end coordinates
  localparam logic [3:0] START_WORD = 4'd8;

  // A legal step moves one cell: x changes (diff 8) or y changes within
  // the same column (diff 1 with x unchanged, so 7 -> 8 is rejected)
  function automatic logic is_adjacent(input logic [COORD_W-1:0] c,
                                       input logic [COORD_W-1:0] p);
    logic [COORD_W-1:0] d;
    d = (c > p) ? (c - p) : (p - c);
    return (d == 6'd8) || ((d == 6'd1) && (c[5:3] == p[5:3]));
  endfunction

endpackage

// File: rtl/path_buf.sv
// Path storage: 64x6 buffer with synchronous write and combinational read.
// Writes beyond DEPTH entries are ignored; the caller flags the overflow.
module path_buf
  import maze_pkg::*;
#(
  parameter int DEPTH = SIZE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [COORD_W-1:0] rd_data,
  output logic [COORD_W-1:0] rd_ptr,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  logic [COORD_W-1:0] mem [SIZE];
  logic [COORD_W-1:0] wr_ptr;
  logic               do_write;

  assign full     = (count >= CNT_W'(DEPTH));
  assign do_write = wr_en && !full && !clr;
  assign rd_data  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clr restarts an empty buffer
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage array is not reset; only pointers define valid contents
  always_ff @(posedge clk) begin
    if (reset && do_write) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/maze_path_checker.sv
// Snoops one maze-solver frame, captures the emitted path, checks
// adjacency, revisits, endpoints and solve timeout, then replays the
// path over a valid/ready port and holds a summary until the next frame.
module maze_path_checker
  import maze_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int DEPTH   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  action_i,
  input  logic [5:0]  coord_i,
  input  logic [15:0] row_i,
  input  logic        rd_ready_i,
  output logic        rd_valid_o,
  output logic [5:0]  rd_coord_o,
  output logic        rd_last_o,
  output logic [6:0]  len_o,
  output logic [3:0]  err_o,
  output logic        done_o
);

  localparam int CAL_W = $clog2(TIMEOUT + 1);

  logic [2:0]         state;
  logic [3:0]         word_cnt;
  logic [CAL_W-1:0]   cal_cnt;
  logic [COORD_W-1:0] start_c;
  logic [COORD_W-1:0] end_c;
  logic [COORD_W-1:0] entry0;
  logic [COORD_W-1:0] prev_c;
  logic [SIZE-1:0]    visited;
  logic [3:0]         err_q;

  logic               start_frame;
  logic               buf_wr;
  logic               buf_rd;
  logic [COORD_W-1:0] buf_data;
  logic [COORD_W-1:0] buf_rd_ptr;
  logic [CNT_W-1:0]   buf_count;
  logic               buf_full;
  logic               is_out;
  logic               unused_row_bits;

  assign unused_row_bits = ^{row_i[15], row_i[11], row_i[7], row_i[3]};
  assign is_out          = (action_i == ACT_OUTPUT);

  path_buf #(.DEPTH(DEPTH)) u_path_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_frame),
    .wr_en   (buf_wr),
    .wr_data (coord_i),
    .rd_en   (buf_rd),
    .rd_data (buf_data),
    .rd_ptr  (buf_rd_ptr),
    .count   (buf_count),
    .full    (buf_full)
  );

  // INPUT restarts a frame from any state except while already snooping;
  // capture writes happen on OUTPUT cycles, reads advance on transfers
  always_comb begin
    start_frame = (action_i == ACT_INPUT) && (state != ST_SNOOP);
    buf_wr      = 1'b0;
    buf_rd      = 1'b0;
    case (state)
      ST_WAIT_CAL: buf_wr = is_out;
      ST_CAPTURE:  buf_wr = is_out;
      ST_DRAIN:    buf_rd = rd_ready_i && !start_frame;
      default: ;
    endcase
  end

  // Read port and summary outputs; coordinate is masked when not valid
  always_comb begin
    rd_valid_o = (state == ST_DRAIN);
    rd_coord_o = rd_valid_o ? buf_data : '0;
    rd_last_o  = rd_valid_o && ({1'b0, buf_rd_ptr} == (buf_count - 1'b1));
    len_o      = buf_count;
    err_o      = err_q;
    done_o     = (state == ST_DONE);
  end

  // Frame state machine together with the path checks
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      cal_cnt  <= '0;
      start_c  <= '0;
      end_c    <= '0;
      entry0   <= '0;
      prev_c   <= '0;
      visited  <= '0;
      err_q    <= '0;
    end else if (start_frame) begin
      state    <= ST_SNOOP;
      word_cnt <= 4'd1;
      cal_cnt  <= '0;
      start_c  <= '0;
      end_c    <= '0;
      entry0   <= '0;
      prev_c   <= '0;
      visited  <= '0;
      err_q    <= '0;
    end else begin
      case (state)
        ST_SNOOP: begin
          if (action_i == ACT_INPUT) begin
            if (word_cnt == START_WORD) begin
              start_c <= {row_i[14:12], row_i[10:8]};
              end_c   <= {row_i[6:4], row_i[2:0]};
            end
            if (word_cnt != 4'hF) begin
              word_cnt <= word_cnt + 1'b1;
            end
          end else begin
            state   <= ST_WAIT_CAL;
            cal_cnt <= (action_i == ACT_CAL) ? CAL_W'(1) : '0;
          end
        end

        ST_WAIT_CAL: begin
          if (is_out) begin
            entry0           <= coord_i;
            prev_c           <= coord_i;
            visited[coord_i] <= 1'b1;
            state            <= ST_CAPTURE;
          end else if (action_i == ACT_CAL) begin
            if (cal_cnt >= CAL_W'(TIMEOUT - 1)) begin
              err_q[ERR_TIMEOUT] <= 1'b1;
              state              <= ST_DONE;
            end else begin
              cal_cnt <= cal_cnt + 1'b1;
            end
          end
        end

        ST_CAPTURE: begin
          if (is_out) begin
            if (!is_adjacent(coord_i, prev_c)) begin
              err_q[ERR_ADJ] <= 1'b1;
            end
            if (visited[coord_i] || buf_full) begin
              err_q[ERR_REVISIT] <= 1'b1;
            end
            visited[coord_i] <= 1'b1;
            prev_c           <= coord_i;
          end else begin
            if ((entry0 != start_c) || (prev_c != end_c)) begin
              err_q[ERR_ENDPT] <= 1'b1;
            end
            state <= (buf_count != '0) ? ST_DRAIN : ST_DONE;
          end
        end

        ST_DRAIN: begin
          if (rd_ready_i && rd_last_o) begin
            state <= ST_DONE;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_path_checker.sv
// Directed bench for maze_path_checker: straight path, restart from DONE,
// column wrap, revisit, endpoint mismatch, timeout, backpressure and reset.
module tb_maze_path_checker;

  localparam logic [1:0] A_IDLE  = 2'b00;
  localparam logic [1:0] A_INPUT = 2'b01;
  localparam logic [1:0] A_CAL   = 2'b10;
  localparam logic [1:0] A_OUT   = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  action_i = A_IDLE;
  logic [5:0]  coord_i = '0;
  logic [15:0] row_i = '0;
  logic        rd_ready_i = 1'b0;
  logic        rd_valid_o;
  logic [5:0]  rd_coord_o;
  logic        rd_last_o;
  logic [6:0]  len_o;
  logic [3:0]  err_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  logic [5:0] path_q[$];

  maze_path_checker #(.TIMEOUT(16), .DEPTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .action_i   (action_i),
    .coord_i    (coord_i),
    .row_i      (row_i),
    .rd_ready_i (rd_ready_i),
    .rd_valid_o (rd_valid_o),
    .rd_coord_o (rd_coord_o),
    .rd_last_o  (rd_last_o),
    .len_o      (len_o),
    .err_o      (err_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Nine INPUT words (word 8 carries start/end), then ncal CAL cycles
  task automatic load_frame(input logic [15:0] word, input int ncal);
    for (int i = 0; i < 9; i++) begin
      action_i = A_INPUT;
      row_i    = (i == 8) ? word : 16'h0;
      step();
    end
    row_i = '0;
    for (int i = 0; i < ncal; i++) begin
      action_i = A_CAL;
      step();
    end
  endtask

  // Emit path_q as OUTPUT cycles, then one IDLE cycle to end capture
  task automatic capture_path();
    foreach (path_q[i]) begin
      action_i = A_OUT;
      coord_i  = path_q[i];
      step();
    end
    action_i = A_IDLE;
    coord_i  = '0;
    step();
  endtask

  task automatic drain_until_done(output int cycles);
    rd_ready_i = 1'b1;
    cycles = 0;
    while (!done_o && cycles < 200) begin
      step();
      cycles++;
    end
    rd_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; action_i = A_IDLE;
    step(); step();
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got=%0b want=0", rd_valid_o); end
    checks++; if (rd_coord_o !== 6'd0) begin errors++; $display("[TB] FAIL reset_rd_coord got=%0d want=0", rd_coord_o); end
    checks++; if (rd_last_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_last got=%0b want=0", rd_last_o); end
    checks++; if (len_o !== 7'd0) begin errors++; $display("[TB] FAIL reset_len got=%0d want=0", len_o); end
    checks++; if (err_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_err got=%b want=0000", err_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b want=0", done_o); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_straight();
    path_q = {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7};
    load_frame(16'h0007, 3);
    capture_path();
    checks++; if (len_o !== 7'd8) begin errors++; $display("[TB] FAIL straight_len got=%0d want=8", len_o); end
    checks++; if (err_o !== 4'b0000) begin errors++; $display("[TB] FAIL straight_err got=%b want=0000", err_o); end
    rd_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL straight_valid[%0d] got=%0b want=1", k, rd_valid_o); end
      checks++; if (rd_coord_o !== 6'(k)) begin errors++; $display("[TB] FAIL straight_coord[%0d] got=%0d want=%0d", k, rd_coord_o, k); end
      checks++; if (rd_last_o !== (k == 7)) begin errors++; $display("[TB] FAIL straight_last[%0d] got=%0b want=%0b", k, rd_last_o, (k == 7)); end
      step();
    end
    rd_ready_i = 1'b0;
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL straight_valid_after got=%0b want=0", rd_valid_o); end
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL straight_done got=%0b want=1", done_o); end
    checks++; if (len_o !== 7'd8) begin errors++; $display("[TB] FAIL straight_len_held got=%0d want=8", len_o); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    action_i = A_INPUT; row_i = 16'h0;
    step();
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_clear got=%0b want=0", done_o); end
    checks++; if (len_o !== 7'd0) begin errors++; $display("[TB] FAIL b2b_len_clear got=%0d want=0", len_o); end
    for (int i = 1; i < 9; i++) begin
      action_i = A_INPUT;
      row_i    = (i == 8) ? 16'h0001 : 16'h0;
      step();
    end
    row_i = '0; action_i = A_CAL;
    step(); step();
    path_q = {6'd0, 6'd1};
    capture_path();
    checks++; if (len_o !== 7'd2) begin errors++; $display("[TB] FAIL b2b_len got=%0d want=2", len_o); end
    checks++; if (err_o !== 4'b0000) begin errors++; $display("[TB] FAIL b2b_err got=%b want=0000", err_o); end
    drain_until_done(cyc);
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done got=%0b want=1 after %0d cycles", done_o, cyc); end
  endtask

  task automatic test_column_wrap();
    int cyc;
    path_q = {6'd7, 6'd8};
    load_frame(16'h0710, 2);
    capture_path();
    checks++; if (err_o !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_err got=%b want=0001", err_o); end
    checks++; if (len_o !== 7'd2) begin errors++; $display("[TB] FAIL wrap_len got=%0d want=2", len_o); end
    drain_until_done(cyc);
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL wrap_done got=%0b want=1", done_o); end
  endtask

  task automatic test_revisit();
    path_q = {6'd0, 6'd8, 6'd0, 6'd1};
    load_frame(16'h0001, 2);
    capture_path();
    checks++; if (err_o !== 4'b0010) begin errors++; $display("[TB] FAIL revisit_err got=%b want=0010", err_o); end
    checks++; if (len_o !== 7'd4) begin errors++; $display("[TB] FAIL revisit_len got=%0d want=4", len_o); end
    rd_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (rd_coord_o !== path_q[k]) begin errors++; $display("[TB] FAIL revisit_coord[%0d] got=%0d want=%0d", k, rd_coord_o, path_q[k]); end
      step();
    end
    rd_ready_i = 1'b0;
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL revisit_done got=%0b want=1", done_o); end
  endtask

  task automatic test_endpoint();
    int cyc;
    path_q = {6'd10, 6'd11};
    load_frame(16'h1113, 2);
    capture_path();
    checks++; if (err_o !== 4'b0100) begin errors++; $display("[TB] FAIL endpoint_err got=%b want=0100", err_o); end
    checks++; if (len_o !== 7'd2) begin errors++; $display("[TB] FAIL endpoint_len got=%0d want=2", len_o); end
    drain_until_done(cyc);
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL endpoint_done got=%0b want=1", done_o); end
  endtask

  task automatic test_timeout();
    load_frame(16'h0007, 0);
    action_i = A_CAL;
    for (int i = 0; i < 15; i++) step();
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early_done got=%0b want=0", done_o); end
    step();
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_done got=%0b want=1", done_o); end
    checks++; if (err_o !== 4'b1000) begin errors++; $display("[TB] FAIL timeout_err got=%b want=1000", err_o); end
    checks++; if (len_o !== 7'd0) begin errors++; $display("[TB] FAIL timeout_len got=%0d want=0", len_o); end
    action_i = A_IDLE;
    step(); step();
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL timeout_valid got=%0b want=0", rd_valid_o); end
  endtask

  task automatic test_backpressure();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int idx = 0;
    path_q = {6'd0, 6'd1, 6'd2, 6'd3};
    load_frame(16'h0003, 2);
    capture_path();
    for (int j = 0; j < 6; j++) begin
      rd_ready_i = pat[j];
      checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d] got=%0b want=1", j, rd_valid_o); end
      checks++; if (rd_coord_o !== 6'(idx)) begin errors++; $display("[TB] FAIL bp_coord[%0d] got=%0d want=%0d", j, rd_coord_o, idx); end
      checks++; if (rd_last_o !== (idx == 3)) begin errors++; $display("[TB] FAIL bp_last[%0d] got=%0b want=%0b", j, rd_last_o, (idx == 3)); end
      step();
      if (pat[j]) idx++;
    end
    rd_ready_i = 1'b0;
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_done got=%0b want=1", done_o); end
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_after got=%0b want=0", rd_valid_o); end
  endtask

  task automatic test_reset_mid_drain();
    path_q = {6'd0, 6'd1, 6'd2, 6'd3};
    load_frame(16'h0007, 2);
    capture_path();
    rd_ready_i = 1'b0;
    checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_valid got=%0b want=1", rd_valid_o); end
    checks++; if (err_o !== 4'b0100) begin errors++; $display("[TB] FAIL mid_err got=%b want=0100", err_o); end
    step();
    reset = 1'b0;
    step();
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got=%0b want=0", rd_valid_o); end
    checks++; if (rd_coord_o !== 6'd0) begin errors++; $display("[TB] FAIL midrst_coord got=%0d want=0", rd_coord_o); end
    checks++; if (rd_last_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_last got=%0b want=0", rd_last_o); end
    checks++; if (len_o !== 7'd0) begin errors++; $display("[TB] FAIL midrst_len got=%0d want=0", len_o); end
    checks++; if (err_o !== 4'd0) begin errors++; $display("[TB] FAIL midrst_err got=%b want=0000", err_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done got=%0b want=0", done_o); end
    reset = 1'b1;
    step();
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL postrst_valid got=%0b want=0", rd_valid_o); end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_back_to_back();
    test_column_wrap();
    test_revisit();
    test_endpoint();
    test_timeout();
    test_backpressure();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
